// File: rtl/led_switch_ctrl.sv
// led_switch_ctrl: slide switches and two push buttons drive a bank of LEDs.
// KEY[0] captures the switches, KEY[1] steps the display mode
// LATCH -> LIVE -> SHIFT. SHIFT rotates the captured pattern left once per tick.
// Optional feature macro: LED_SWITCH_DEBOUNCE_EN enables per-key debounce
// counters. Without it the synchronized key level is used directly.

module led_switch_ctrl #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int TICK_CYCLES     = 25000000
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] SW,
    input  logic [1:0]       KEY,
    output logic [WIDTH-1:0] LEDR,
    output logic [1:0]       MODE
);

    typedef enum logic [1:0] {
        ModeLatch = 2'b00,
        ModeLive  = 2'b01,
        ModeShift = 2'b10
    } mode_e;

    localparam int TickW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [TickW-1:0] TickLast = TickW'(TICK_CYCLES - 1);

    logic [WIDTH-1:0] swSync1_q, swSync2_q;
    logic [1:0]       keySync1_q, keySync2_q;
    logic [1:0]       keyDeb_q;
    logic [1:0]       keyPrev_q;
    logic [1:0]       press;
    logic             capPulse, modePulse;

    mode_e            mode_q, mode_d;
    logic [WIDTH-1:0] capture_q, capture_d;
    logic [WIDTH-1:0] rotate_q, rotate_d;
    logic [WIDTH-1:0] rotl;
    logic [TickW-1:0] tick_q, tick_d;
    logic [WIDTH-1:0] ledr_q, ledr_d;

    // Two-flop synchronizers; keys idle high (released) out of reset
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            swSync1_q  <= '0;
            swSync2_q  <= '0;
            keySync1_q <= 2'b11;
            keySync2_q <= 2'b11;
        end else begin
            swSync1_q  <= SW;
            swSync2_q  <= swSync1_q;
            keySync1_q <= KEY;
            keySync2_q <= keySync1_q;
        end
    end

`ifdef LED_SWITCH_DEBOUNCE_EN
    localparam int DebW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DebW-1:0] DebLast = DebW'(DEBOUNCE_CYCLES - 1);

    logic [DebW-1:0] debCnt_q [2];

    // Accept a new key level only after it has disagreed for DEBOUNCE_CYCLES cycles in a row
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            keyDeb_q <= 2'b11;
            for (int k = 0; k < 2; k++) begin
                debCnt_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (keySync2_q[k] == keyDeb_q[k]) begin
                    debCnt_q[k] <= '0;
                end else if (debCnt_q[k] == DebLast) begin
                    keyDeb_q[k] <= keySync2_q[k];
                    debCnt_q[k] <= '0;
                end else begin
                    debCnt_q[k] <= debCnt_q[k] + DebW'(1);
                end
            end
        end
    end
`else
    // No debounce: the synchronized level is taken as the debounced level
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            keyDeb_q <= 2'b11;
        end else begin
            keyDeb_q <= keySync2_q;
        end
    end
`endif

    // Remember the previous debounced level so only a 1->0 transition makes a pulse
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            keyPrev_q <= 2'b11;
        end else begin
            keyPrev_q <= keyDeb_q;
        end
    end

    assign press     = keyPrev_q & ~keyDeb_q;
    assign capPulse  = press[0];
    assign modePulse = press[1];
    assign rotl      = (rotate_q << 1) | (rotate_q >> (WIDTH - 1));

    // Next-state for mode, capture, rotate and tick; LED value follows the new state
    always_comb begin
        mode_d    = ModeLatch;
        capture_d = capture_q;
        rotate_d  = rotate_q;
        tick_d    = tick_q;
        ledr_d    = '0;

        if (capPulse) begin
            capture_d = swSync2_q;
        end

        case (mode_q)
            ModeLatch: mode_d = modePulse ? ModeLive  : ModeLatch;
            ModeLive:  mode_d = modePulse ? ModeShift : ModeLive;
            ModeShift: mode_d = modePulse ? ModeLatch : ModeShift;
            default:   mode_d = ModeLatch;
        endcase

        if (mode_d == ModeShift) begin
            if ((mode_q != ModeShift) || capPulse) begin
                rotate_d = capture_d;
                tick_d   = '0;
            end else if (tick_q == TickLast) begin
                rotate_d = rotl;
                tick_d   = '0;
            end else begin
                tick_d = tick_q + TickW'(1);
            end
        end else begin
            tick_d = '0;
        end

        case (mode_d)
            ModeLive:  ledr_d = swSync2_q;
            ModeShift: ledr_d = rotate_d;
            default:   ledr_d = capture_d;
        endcase
    end

    // Mode FSM and datapath registers, LED drive registered
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            mode_q    <= ModeLatch;
            capture_q <= '0;
            rotate_q  <= '0;
            tick_q    <= '0;
            ledr_q    <= '0;
        end else begin
            mode_q    <= mode_d;
            capture_q <= capture_d;
            rotate_q  <= rotate_d;
            tick_q    <= tick_d;
            ledr_q    <= ledr_d;
        end
    end

    assign LEDR = ledr_q;
    assign MODE = mode_q;

endmodule

// File: doc/led_switch_ctrl.md
LED_SWITCH_CTRL -- requirements
Module: led_switch_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8: number of switches and LEDs.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 500000: consecutive stable cycles required before a key level is accepted.
REQ-003 SHALL have parameter TICK_CYCLES, default 25000000: clock cycles per rotate step in SHIFT mode.
REQ-004 SHALL have port CLK, input, 1 bit: single system clock, all logic on rising edge.
REQ-005 SHALL have port RST_N, input, 1 bit: synchronous reset, active-low.
REQ-006 SHALL have port SW, input, WIDTH bits: asynchronous slide switches.
REQ-007 SHALL have port KEY, input, 2 bits: asynchronous push buttons, active-low (pressed = 0); KEY[0] = capture, KEY[1] = mode step.
REQ-008 SHALL have port LEDR, output, WIDTH bits: registered LED drive.
REQ-009 SHALL have port MODE, output, 2 bits: current mode (00 LATCH, 01 LIVE, 10 SHIFT).

Function
REQ-010 SHALL pass each KEY bit and SW through a two-flop synchronizer before any use.
REQ-011 SHALL, per key, update the debounced level only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
REQ-012 SHALL generate a one-cycle press pulse on the debounced 1->0 transition only; release generates nothing; a held key generates exactly one pulse.
REQ-013 SHALL, on a KEY[0] press pulse, load the capture register with synchronized SW on the following edge.
REQ-014 SHALL, on a KEY[1] press pulse, step mode LATCH->LIVE->SHIFT->LATCH; code 11 is unreachable and SHALL recover to LATCH.
REQ-015 SHALL drive LEDR = capture register in LATCH mode.
REQ-016 SHALL drive LEDR = synchronized SW, registered, in LIVE mode (total 3-cycle SW-to-LEDR latency).
REQ-017 SHALL, on entering SHIFT, load the rotate register from the capture register and clear the tick counter.
REQ-018 SHALL in SHIFT rotate the rotate register left by one (MSB to LSB) when the tick counter reaches TICK_CYCLES-1, counter wrapping to 0; LEDR = rotate register.
REQ-019 SHALL, on KEY[0] press in SHIFT, load both capture and rotate registers with SW and clear the tick counter.
REQ-020 SHALL, on simultaneous KEY[0] and KEY[1] pulses, perform capture and mode step in the same cycle; the new mode uses the newly captured value.
REQ-021 SHALL, on leaving SHIFT for LATCH, show the capture register, not the rotated value.

Reset
REQ-022 SHALL, while RST_N = 0 at a rising edge, clear LEDR, capture, rotate and tick registers to 0, set MODE to LATCH, set debounced key levels to 1 (released), and clear debounce counters and synchronizers (keys to 1).
REQ-023 SHALL, when reset is applied mid-debounce or mid-rotate, abandon the operation with no press pulse on release of reset.

Configuration
REQ-024 SHALL, with macro LED_SWITCH_DEBOUNCE_EN defined, debounce per REQ-011.
REQ-025 SHALL, without LED_SWITCH_DEBOUNCE_EN, use the synchronized key level directly as the debounced level (press pulse 1 cycle after synchronizer output falls); DEBOUNCE_CYCLES ignored.

Verification (WIDTH=8, DEBOUNCE_CYCLES=4, TICK_CYCLES=3, macro defined)
REQ-026 SHALL cover reset: RST_N=0 two cycles, SW=8'hFF -> LEDR=8'h00, MODE=00 after release.
REQ-027 SHALL cover capture: SW=8'b0110_1010, KEY[0] low 10 cycles -> LEDR=8'b0110_1010 in LATCH; later SW=8'h00 -> LEDR unchanged.
REQ-028 SHALL cover bounce: KEY[0] low 3 cycles, high 1, low 3, high -> no capture, LEDR unchanged.
REQ-029 SHALL cover modes: two KEY[1] presses from LATCH with capture 8'b1000_0001 -> MODE=10, LEDR 8'b1000_0001, then 8'b0000_0011 three cycles later, then 8'b0000_0110.
REQ-030 SHALL cover simultaneous press: in LIVE, SW=8'h5A, both keys pressed together -> MODE=10, rotate starts from 8'h5A.
REQ-031 SHALL cover macro undefined: single-cycle KEY[0] low pulse -> capture occurs.
